buck_pwm_gen: RTL and testbench

BUCK_PWM_GEN -- requirements
Module: buck_pwm_gen

---
 rtl/discharge_pkg.sv | 26 ++
 rtl/pwm_phase.sv | 53 +++++
 rtl/buck_pwm_gen.sv | 107 ++++++++++
 tb/tb_buck_pwm_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/discharge_pkg.sv
// Shared constants and state encodings for the discharge controller and its buck PWM generator.
package discharge_pkg;

    localparam logic [15:0] DEF_PWM_PERIOD_TICKS = 16'd200;
    localparam logic [15:0] DEF_MIN_OFF_TICKS    = 16'd20;

    typedef enum logic [2:0] {
        DIS_IDLE            = 3'd0,
        DIS_PRECHARGE       = 3'd1,
        DIS_BUCK_INTERLEAVE = 3'd2,
        DIS_BLEED           = 3'd3,
        DIS_DONE            = 3'd4
    } discharge_state_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } buck_state_e;

    function automatic logic [15:0] clamp_duty(input logic [15:0] req_ticks,
                                               input logic [15:0] max_ticks);
        return (req_ticks > max_ticks) ? max_ticks : req_ticks;
    endfunction

endpackage

// File: rtl/pwm_phase.sv
// One buck phase: latches the clamped duty and decides the next gate level from the shared tick.
module pwm_phase
    import discharge_pkg::*;
#(
    parameter logic [15:0] PERIOD_TICKS  = DEF_PWM_PERIOD_TICKS,
    parameter logic [15:0] MIN_OFF_TICKS = DEF_MIN_OFF_TICKS,
    parameter logic [15:0] START_TICK    = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_run,
    input  logic        i_latch,
    input  logic        i_gate,
    input  logic [15:0] i_tick,
    input  logic [15:0] i_charge_time,
    output logic        o_gate_next
);
    localparam logic [15:0] SHIFT_TICKS = PERIOD_TICKS - START_TICK;

    logic [15:0] r_duty;
    logic [15:0] w_duty_new;
    logic [16:0] w_tick_sum;
    logic [15:0] w_rel_tick;

    assign w_duty_new = clamp_duty(i_charge_time, PERIOD_TICKS - MIN_OFF_TICKS);

    // Tick position relative to this phase's start, modulo the period.
    assign w_tick_sum = {1'b0, i_tick} + {1'b0, SHIFT_TICKS};
    assign w_rel_tick = (w_tick_sum >= {1'b0, PERIOD_TICKS}) ? (w_tick_sum[15:0] - PERIOD_TICKS)
                                                              : w_tick_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
        end else if (i_run && i_latch) begin
            r_duty <= w_duty_new;
        end
    end

    always_comb begin
        o_gate_next = 1'b0;
        if (!i_run) begin
            o_gate_next = 1'b0;
        end else if (i_latch) begin
            o_gate_next = (w_duty_new != '0);
        end else if (i_gate && (w_rel_tick == r_duty - 16'd1)) begin
            o_gate_next = 1'b0;
        end else begin
            o_gate_next = i_gate;
        end
    end

endmodule

// File: rtl/buck_pwm_gen.sv
// Two-phase interleaved buck PWM generator; the FSM tracks phase A, phase B runs half a period later.
module buck_pwm_gen
    import discharge_pkg::*;
#(
    parameter logic [15:0] PWM_PERIOD_TICKS = DEF_PWM_PERIOD_TICKS,
    parameter logic [15:0] MIN_OFF_TICKS    = DEF_MIN_OFF_TICKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        buck_en,
    input  logic [15:0] inductor_charging_time,
    output logic        gate_a,
    output logic        gate_b,
    output logic [15:0] timer_cycle_num,
    output logic        cycle_start
);
    localparam logic [15:0] LAST_TICK    = PWM_PERIOD_TICKS - 16'd1;
    localparam logic [15:0] HALF_TICKS   = PWM_PERIOD_TICKS >> 1;
    localparam logic [15:0] B_LATCH_TICK = HALF_TICKS - 16'd1;

    buck_state_e r_state;
    logic [15:0] r_tick;
    logic [15:0] r_timer;
    logic        r_cycle_start;
    logic        r_gate_a;
    logic        r_gate_b;

    logic w_active;
    logic w_latch_a;
    logic w_run_b;
    logic w_latch_b;
    logic w_gate_a_next;
    logic w_gate_b_next;

    assign w_active  = (r_state != S_IDLE);
    assign w_latch_a = buck_en && (!w_active || (r_tick == LAST_TICK));
    assign w_run_b   = buck_en && w_active;
    assign w_latch_b = w_run_b && (r_tick == B_LATCH_TICK);

    pwm_phase #(
        .PERIOD_TICKS (PWM_PERIOD_TICKS),
        .MIN_OFF_TICKS(MIN_OFF_TICKS),
        .START_TICK   (16'd0)
    ) u_phase_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (buck_en),
        .i_latch      (w_latch_a),
        .i_gate       (r_gate_a),
        .i_tick       (r_tick),
        .i_charge_time(inductor_charging_time),
        .o_gate_next  (w_gate_a_next)
    );

    pwm_phase #(
        .PERIOD_TICKS (PWM_PERIOD_TICKS),
        .MIN_OFF_TICKS(MIN_OFF_TICKS),
        .START_TICK   (HALF_TICKS)
    ) u_phase_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (w_run_b),
        .i_latch      (w_latch_b),
        .i_gate       (r_gate_b),
        .i_tick       (r_tick),
        .i_charge_time(inductor_charging_time),
        .o_gate_next  (w_gate_b_next)
    );

    // Phase-A state follows the same next-gate decision that drives r_gate_a, so S_ON == gate_a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_timer       <= '0;
            r_cycle_start <= 1'b0;
            r_gate_a      <= 1'b0;
            r_gate_b      <= 1'b0;
        end else begin
            r_gate_a      <= w_gate_a_next;
            r_gate_b      <= w_gate_b_next;
            r_cycle_start <= 1'b0;
            if (!buck_en) begin
                r_state <= S_IDLE;
                r_tick  <= '0;
            end else if (w_latch_a) begin
                r_state       <= w_gate_a_next ? S_ON : S_OFF;
                r_tick        <= '0;
                r_cycle_start <= 1'b1;
                if (!w_active) begin
                    r_timer <= '0;
                end else if (r_timer != '1) begin
                    r_timer <= r_timer + 16'd1;
                end
            end else begin
                r_state <= w_gate_a_next ? S_ON : S_OFF;
                r_tick  <= r_tick + 16'd1;
            end
        end
    end

    assign gate_a          = r_gate_a;
    assign gate_b          = r_gate_b;
    assign timer_cycle_num = r_timer;
    assign cycle_start     = r_cycle_start;

endmodule

// File: tb/tb_buck_pwm_gen.sv
// Self-checking bench for buck_pwm_gen: segment table, hand-written corner sequences, random soak.
module tb_buck_pwm_gen;
    localparam int P    = 200;
    localparam int MO   = 20;
    localparam int HALF = P / 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        buck_en;
    logic [15:0] ict;
    logic        gate_a;
    logic        gate_b;
    logic [15:0] timer_cycle_num;
    logic        cycle_start;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: position within the phase-A period plus latched duties.
    bit m_active, m_bstart, m_ga, m_gb, m_cs;
    int m_pos, m_duty_a, m_duty_b, m_timer;

    int seg_ga, seg_gb, seg_cs;
    int per_cnt[3];
    int picks[8] = '{0, 1, 80, 120, 179, 180, 181, 65535};

    typedef struct {
        bit en;
        int ict;
        int cycles;
        int exp_ga;
        int exp_gb;
        int exp_cs;
        int exp_timer;
    } seg_t;
    seg_t tbl[5];

    buck_pwm_gen #(
        .PWM_PERIOD_TICKS(16'd200),
        .MIN_OFF_TICKS   (16'd20)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .buck_en               (buck_en),
        .inductor_charging_time(ict),
        .gate_a                (gate_a),
        .gate_b                (gate_b),
        .timer_cycle_num       (timer_cycle_num),
        .cycle_start           (cycle_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int t);
        return (t > P - MO) ? (P - MO) : t;
    endfunction

    task automatic model_reset();
        m_active = 0; m_bstart = 0; m_ga = 0; m_gb = 0; m_cs = 0;
        m_pos = 0; m_duty_a = 0; m_duty_b = 0; m_timer = 0;
    endtask

    task automatic model_edge(input bit en, input int t);
        if (!en) begin
            m_active = 0; m_bstart = 0; m_ga = 0; m_gb = 0; m_cs = 0;
        end else begin
            if (!m_active || m_pos == P - 1) begin
                m_timer  = !m_active ? 0 : ((m_timer == 65535) ? 65535 : m_timer + 1);
                m_active = 1;
                m_pos    = 0;
                m_duty_a = clamp(t);
                m_cs     = 1;
            end else begin
                if (m_pos == HALF - 1) begin
                    m_duty_b = clamp(t);
                    m_bstart = 1;
                end
                m_pos++;
                m_cs = 0;
            end
            m_ga = (m_pos < m_duty_a);
            m_gb = m_bstart && (((m_pos + P - HALF) % P) < m_duty_b);
        end
    endtask

    task automatic check_all();
        chk("gate_a", int'(gate_a), int'(m_ga));
        chk("gate_b", int'(gate_b), int'(m_gb));
        chk("cycle_start", int'(cycle_start), int'(m_cs));
        chk("timer_cycle_num", int'(timer_cycle_num), m_timer);
    endtask

    task automatic step(input bit en, input int t);
        logic [31:0] tv;
        tv      = t;
        buck_en = en;
        ict     = tv[15:0];
        @(posedge clk);
        model_edge(en, t);
        #1;
        check_all();
        seg_ga += int'(gate_a);
        seg_gb += int'(gate_b);
        seg_cs += int'(cycle_start);
    endtask

    initial begin
        int cur;
        int off_left;

        tbl[0] = '{en: 1, ict: 80,  cycles: 400, exp_ga: 160, exp_gb: 160, exp_cs: 2, exp_timer: 1};
        tbl[1] = '{en: 1, ict: 250, cycles: 200, exp_ga: 180, exp_gb: 100, exp_cs: 1, exp_timer: 2};
        tbl[2] = '{en: 1, ict: 0,   cycles: 400, exp_ga: 0,   exp_gb: 80,  exp_cs: 2, exp_timer: 4};
        tbl[3] = '{en: 0, ict: 80,  cycles: 10,  exp_ga: 0,   exp_gb: 0,   exp_cs: 0, exp_timer: 4};
        tbl[4] = '{en: 1, ict: 80,  cycles: 200, exp_ga: 80,  exp_gb: 80,  exp_cs: 1, exp_timer: 0};

        rst_n   = 1'b0;
        buck_en = 1'b0;
        ict     = 16'd0;
        model_reset();
        #12;
        chk("reset_gate_a", int'(gate_a), 0);
        chk("reset_gate_b", int'(gate_b), 0);
        chk("reset_cycle_start", int'(cycle_start), 0);
        chk("reset_timer", int'(timer_cycle_num), 0);
        rst_n = 1'b1;

        for (int s = 0; s < 5; s++) begin
            seg_ga = 0; seg_gb = 0; seg_cs = 0;
            for (int c = 0; c < tbl[s].cycles; c++) step(tbl[s].en, tbl[s].ict);
            chk($sformatf("seg%0d_gate_a_high", s), seg_ga, tbl[s].exp_ga);
            chk($sformatf("seg%0d_gate_b_high", s), seg_gb, tbl[s].exp_gb);
            chk($sformatf("seg%0d_cycle_starts", s), seg_cs, tbl[s].exp_cs);
            chk($sformatf("seg%0d_timer_end", s), int'(timer_cycle_num), tbl[s].exp_timer);
        end

        // Mid-period charging-time changes take effect only at the next period.
        step(0, 80);
        per_cnt = '{0, 0, 0};
        for (int c = 0; c < 600; c++) begin
            cur = (c < 30) ? 80 : (c < 230) ? 120 : 80;
            step(1, cur);
            per_cnt[c / 200] += int'(gate_a);
        end
        chk("midchg_period0_high", per_cnt[0], 80);
        chk("midchg_period1_high", per_cnt[1], 120);
        chk("midchg_period2_high", per_cnt[2], 80);

        // Disable at tick 50 of the fourth period, then re-enable.
        for (int c = 0; c < 51; c++) step(1, 80);
        chk("pre_drop_gate_a", int'(gate_a), 1);
        step(0, 80);
        chk("drop_gate_a", int'(gate_a), 0);
        chk("drop_gate_b", int'(gate_b), 0);
        chk("drop_timer_held", int'(timer_cycle_num), 3);
        for (int c = 0; c < 5; c++) step(0, 80);
        chk("idle_timer_held", int'(timer_cycle_num), 3);
        step(1, 80);
        chk("reen_timer", int'(timer_cycle_num), 0);
        chk("reen_cycle_start", int'(cycle_start), 1);
        chk("reen_gate_a", int'(gate_a), 1);

        // Asynchronous reset while phase A is on.
        for (int c = 0; c < 10; c++) step(1, 80);
        chk("pre_rst_gate_a", int'(gate_a), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_gate_a", int'(gate_a), 0);
        chk("async_rst_gate_b", int'(gate_b), 0);
        chk("async_rst_cycle_start", int'(cycle_start), 0);
        chk("async_rst_timer", int'(timer_cycle_num), 0);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step(0, 80);

        // Random soak against the model.
        cur = 80;
        off_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (off_left > 0) off_left--;
            else if ($urandom_range(299) == 0) off_left = int'($urandom_range(5, 1));
            if ($urandom_range(49) == 0) cur = picks[$urandom_range(7)];
            step(off_left == 0, cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
